io_input_sequencer: RTL and testbench
=====================================

// Module: io_input_sequencer
// PURPOSE
//  Sequences switch input reads for the single-cycle core. When the fetched instruction
//  reads the switch port, it holds the PC until the user presses a debounced
//  confirm_button. It then latches the switches and releases the instruction to complete.
//  Sits between Controller (IORead), MemOrIO (SwitchCtrl), IFetch (PC hold) and ioread (data).
// PARAMETERS
//  DB_CYCLES   200000  clocks the synchronised button must stay unchanged before the debounced level updates
//  DB_W        18      debounce counter width; must satisfy 2^DB_W > DB_CYCLES
//  TO_CYCLES   24'hFFFFFF  press timeout in clocks (used only with IO_TIMEOUT_EN)
// PORTS
//  clock           in   1   core clock (clk1 domain)
//  rst             in   1   synchronous reset, active-high
//  io_read         in   1   IORead from Controller for the current instruction
//  switch_ctrl     in   1   SwitchCtrl from MemOrIO: switch port addressed
//  switches        in   16  raw board switches
//  confirm_button  in   1   raw, asynchronous push button
//  pc_hold         out  1   to IFetch: 1 = do not update PC this cycle
//  io_rdata        out  16  latched switch value, to ioread
//  io_valid        out  1   1-cycle pulse: io_rdata is fresh and this is the completing cycle
//  io_timeout      out  1   sticky: last read ended by timeout
// BEHAVIOUR
//  One clock; reset is synchronous and active-high. Ports are named clock and rst.
//  Reset values: state=IDLE, pc_hold=0, io_rdata=0, io_valid=0, io_timeout=0.
//    Synchroniser flops, debounce counter, btn_stable and btn_prev also reset to 0.
//  Synchroniser: 2 flops on confirm_button -> btn_sync.
//  Debounce:
//    - btn_sync==btn_stable: counter cleared.
//    - Otherwise the counter increments; at DB_CYCLES-1, btn_stable<=btn_sync and the counter clears.
//  press = btn_stable & ~btn_prev, where btn_prev is btn_stable delayed one clock.
//    - Only a fresh rising edge counts.
//    - A button already held when the request arrives does not count.
//  req = io_read & switch_ctrl. An io_read without switch_ctrl is ignored (pc_hold=0).
//  FSM (2-bit):
//    IDLE:    pc_hold=req (combinational, same cycle). req -> WAIT.
//    WAIT:    pc_hold=1.
//             - press -> DONE; io_rdata<=switches sampled at the press cycle.
//             - req dropping is impossible while the PC is held; if it occurs anyway -> IDLE.
//    DONE:    pc_hold=0, io_valid=1. The instruction completes and the PC advances at this edge.
//             Unconditionally -> IDLE, even though req is still high this cycle.
//  Latency: request to release = time to press + 1 clock (the press edge registers into DONE).
//  Back-to-back reads: the next read enters WAIT and needs a new release + press.
//  press in IDLE or DONE: ignored, not queued.
//  io_rdata holds its value until the next completed read.
//  rst mid-WAIT: state goes to IDLE and pc_hold drops the same cycle (the reset cycle).
// CONFIGURATION
//  IO_TIMEOUT_EN defined:
//    - A timeout counter clears on entering WAIT and counts every WAIT cycle.
//    - Reaching TO_CYCLES-1 -> DONE with io_rdata<=16'h0000 and io_timeout<=1.
//    - A completed press clears io_timeout.
//  IO_TIMEOUT_EN undefined:
//    - No timeout counter; WAIT lasts indefinitely.
//    - io_timeout is tied to 0.
// TESTING (bench: DB_CYCLES=4, TO_CYCLES=64)
//  1 rst=1 for 2 clocks with button and io_read high
//    -> pc_hold=0, io_rdata=0, io_valid=0 throughout and the clock after.
//  2 req=1, switches=16'hA5C3, button pressed after 10 clocks
//    -> pc_hold=1 from req until press is registered;
//    -> one DONE cycle with io_valid=1, io_rdata=16'hA5C3, pc_hold=0.
//  3 Glitchy button (2-cycle pulses) during WAIT
//    -> no io_valid, pc_hold stays 1; a clean 8-cycle press then completes.
//  4 Button held through DONE, second req immediately
//    -> stays in WAIT until release + new press; io_valid pulses exactly twice total.
//  5 io_read=1, switch_ctrl=0 -> pc_hold=0, io_rdata unchanged, no io_valid.
//  6 [IO_TIMEOUT_EN] req with no press
//    -> after 64 WAIT clocks: io_valid=1, io_rdata=0, io_timeout=1;
//    -> next pressed read clears io_timeout to 0.

Source files
------------

// File: rtl/io_input_sequencer.sv
// io_input_sequencer: stalls the single-cycle core on a switch-port read until the
// user presses a debounced confirm button, then latches the switches and releases
// the instruction for exactly one completing cycle.
// Optional feature: define IO_TIMEOUT_EN to bound the wait with a press timeout.
module io_input_sequencer #(
  parameter int unsigned DB_CYCLES = 200000,
  parameter int unsigned DB_W      = 18,
  parameter logic [23:0] TO_CYCLES = 24'hFFFFFF
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        io_read,
  input  logic        switch_ctrl,
  input  logic [15:0] switches,
  input  logic        confirm_button,
  output logic        pc_hold,
  output logic [15:0] io_rdata,
  output logic        io_valid,
  output logic        io_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  state_t          state;
  state_t          state_next;
  logic            btn_meta;
  logic            btn_sync;
  logic            btn_stable;
  logic            btn_prev;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            req;
  logic            to_expire;
  logic            capture_press;
  logic            capture_timeout;

  // Two-flop synchroniser for the asynchronous button.
  // NOTE: flops always use non-blocking assignments so every register samples the pre-edge value of its source.
  always_ff @(posedge clock) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= confirm_button;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: the stable level follows btn_sync only after DB_CYCLES unchanged clocks.
  always_ff @(posedge clock) begin
    if (rst) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
      btn_prev   <= 1'b0;
    end else begin
      btn_prev <= btn_stable;
      if (btn_sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_sync;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Only a fresh rising edge of the debounced level counts as a press.
  assign press = btn_stable & ~btn_prev;
  assign req   = io_read & switch_ctrl;

`ifdef IO_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = TO_CYCLES - 24'd1;

  logic [23:0] to_cnt;

  // Timeout counter: zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clock) begin
    if (rst || state != WAIT) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 24'd1;
    end
  end

  assign to_expire = (to_cnt == TO_LAST);

  // Sticky timeout flag: set by a timed-out read, cleared by a pressed read.
  always_ff @(posedge clock) begin
    if (rst) begin
      io_timeout <= 1'b0;
    end else if (capture_timeout) begin
      io_timeout <= 1'b1;
    end else if (capture_press) begin
      io_timeout <= 1'b0;
    end
  end
`else
  logic unused_to_cfg;

  assign unused_to_cfg = ^TO_CYCLES;
  assign to_expire     = 1'b0;
  assign io_timeout    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs; reset forces pc_hold low in the reset cycle itself.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next      = state;
    pc_hold         = 1'b0;
    io_valid        = 1'b0;
    capture_press   = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      IDLE: begin
        pc_hold = req;
        if (req) state_next = WAIT;
      end
      WAIT: begin
        pc_hold = 1'b1;
        if (press) begin
          state_next    = DONE;
          capture_press = 1'b1;
        end else if (!req) begin
          state_next = IDLE;
        end else if (to_expire) begin
          state_next      = DONE;
          capture_timeout = 1'b1;
        end
      end
      DONE: begin
        io_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      pc_hold  = 1'b0;
      io_valid = 1'b0;
    end
  end

  // Read data: switches at the press cycle, zero on timeout, held otherwise.
  always_ff @(posedge clock) begin
    if (rst) begin
      io_rdata <= '0;
    end else if (capture_press) begin
      io_rdata <= switches;
    end else if (capture_timeout) begin
      io_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_io_input_sequencer.sv
// Directed bench for io_input_sequencer with DB_CYCLES=4 and TO_CYCLES=64.
module tb_io_input_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic        io_read;
  logic        switch_ctrl;
  logic [15:0] switches;
  logic        confirm_button;
  logic        pc_hold;
  logic [15:0] io_rdata;
  logic        io_valid;
  logic        io_timeout;

  int checks   = 0;
  int failures = 0;
  int valid_seen = 0;

  io_input_sequencer #(
    .DB_CYCLES(4),
    .DB_W     (3),
    .TO_CYCLES(24'd64)
  ) dut (
    .clock         (clock),
    .rst           (rst),
    .io_read       (io_read),
    .switch_ctrl   (switch_ctrl),
    .switches      (switches),
    .confirm_button(confirm_button),
    .pc_hold       (pc_hold),
    .io_rdata      (io_rdata),
    .io_valid      (io_valid),
    .io_timeout    (io_timeout)
  );

  always #5 clock = ~clock;

  // Count completing cycles as they are clocked out.
  always @(posedge clock) if (io_valid === 1'b1) valid_seen++;

  // Bounded wait for io_valid; reports whether it came and whether pc_hold stayed high before it.
  task automatic wait_valid(input int budget, output bit got, output bit hold_ok);
    got = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (io_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (pc_hold !== 1'b1) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; io_read = 1'b1; switch_ctrl = 1'b1; switches = 16'hFFFF; confirm_button = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({pc_hold, io_valid, io_rdata} !== {1'b0, 1'b0, 16'h0000}) begin
        $display("FAIL reset_outputs cycle=%0d got hold=%b valid=%b rdata=%h exp 0 0 0000", i, pc_hold, io_valid, io_rdata);
        failures++;
      end
    end
    rst = 1'b0; io_read = 1'b0; switch_ctrl = 1'b0; confirm_button = 1'b0;
    @(negedge clock);
    checks++;
    if ({pc_hold, io_valid, io_rdata, io_timeout} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
      $display("FAIL reset_after got hold=%b valid=%b rdata=%h to=%b exp 0 0 0000 0", pc_hold, io_valid, io_rdata, io_timeout);
      failures++;
    end
  endtask

  task automatic test_basic_read;
    bit got, hold_ok;
    switches = 16'hA5C3; io_read = 1'b1; switch_ctrl = 1'b1;
    #1;
    checks++;
    if (pc_hold !== 1'b1) begin
      $display("FAIL basic_hold_same_cycle got=%b exp=1", pc_hold);
      failures++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({pc_hold, io_valid} !== 2'b10) begin
        $display("FAIL basic_wait cycle=%0d got hold=%b valid=%b exp 1 0", i, pc_hold, io_valid);
        failures++;
      end
    end
    confirm_button = 1'b1;
    wait_valid(30, got, hold_ok);
    checks++;
    if ({got, hold_ok} !== 2'b11) begin
      $display("FAIL basic_release got valid_seen=%b hold_ok=%b exp 1 1", got, hold_ok);
      failures++;
    end
    checks++;
    if ({pc_hold, io_rdata, io_timeout} !== {1'b0, 16'hA5C3, 1'b0}) begin
      $display("FAIL basic_done got hold=%b rdata=%h to=%b exp 0 a5c3 0", pc_hold, io_rdata, io_timeout);
      failures++;
    end
    io_read = 1'b0;
    @(negedge clock);
    checks++;
    if ({pc_hold, io_valid, io_rdata} !== {1'b0, 1'b0, 16'hA5C3}) begin
      $display("FAIL basic_single_pulse got hold=%b valid=%b rdata=%h exp 0 0 a5c3", pc_hold, io_valid, io_rdata);
      failures++;
    end
    confirm_button = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_glitch;
    bit got, hold_ok;
    switches = 16'h1234; io_read = 1'b1; switch_ctrl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      confirm_button = (i < 12) && ((i % 4) < 2);
      @(negedge clock);
      checks++;
      if ({pc_hold, io_valid} !== 2'b10) begin
        $display("FAIL glitch_wait cycle=%0d got hold=%b valid=%b exp 1 0", i, pc_hold, io_valid);
        failures++;
      end
    end
    confirm_button = 1'b1;
    wait_valid(8, got, hold_ok);
    confirm_button = 1'b0;
    checks++;
    if ({got, hold_ok, io_rdata} !== {1'b1, 1'b1, 16'h1234}) begin
      $display("FAIL glitch_clean_press got valid=%b hold_ok=%b rdata=%h exp 1 1 1234", got, hold_ok, io_rdata);
      failures++;
    end
    io_read = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    bit got, hold_ok;
    int v0;
    v0 = valid_seen;
    switches = 16'hBEEF; io_read = 1'b1; switch_ctrl = 1'b1; confirm_button = 1'b1;
    wait_valid(20, got, hold_ok);
    checks++;
    if ({got, hold_ok, io_rdata} !== {1'b1, 1'b1, 16'hBEEF}) begin
      $display("FAIL b2b_first got valid=%b hold_ok=%b rdata=%h exp 1 1 beef", got, hold_ok, io_rdata);
      failures++;
    end
    switches = 16'h0F0F;
    for (int i = 0; i < 25; i++) begin
      if (i == 15) confirm_button = 1'b0;
      @(negedge clock);
      checks++;
      if ({pc_hold, io_valid} !== 2'b10) begin
        $display("FAIL b2b_held_wait cycle=%0d got hold=%b valid=%b exp 1 0", i, pc_hold, io_valid);
        failures++;
      end
    end
    confirm_button = 1'b1;
    wait_valid(20, got, hold_ok);
    checks++;
    if ({got, hold_ok, io_rdata} !== {1'b1, 1'b1, 16'h0F0F}) begin
      $display("FAIL b2b_second got valid=%b hold_ok=%b rdata=%h exp 1 1 0f0f", got, hold_ok, io_rdata);
      failures++;
    end
    io_read = 1'b0;
    @(negedge clock);
    confirm_button = 1'b0;
    checks++;
    if (valid_seen - v0 !== 2) begin
      $display("FAIL b2b_pulse_count got=%0d exp=2", valid_seen - v0);
      failures++;
    end
    repeat (12) @(negedge clock);
  endtask

  task automatic test_no_switch_ctrl;
    switches = 16'h7777; io_read = 1'b1; switch_ctrl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      confirm_button = (i < 8);
      @(negedge clock);
      checks++;
      if ({pc_hold, io_valid, io_rdata} !== {1'b0, 1'b0, 16'h0F0F}) begin
        $display("FAIL ignore_read cycle=%0d got hold=%b valid=%b rdata=%h exp 0 0 0f0f", i, pc_hold, io_valid, io_rdata);
        failures++;
      end
    end
    io_read = 1'b0;
    confirm_button = 1'b0;
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout;
    bit got, hold_ok;
    switches = 16'h3C3C; io_read = 1'b1; switch_ctrl = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(negedge clock);
      checks++;
      if (i < 64) begin
        if ({pc_hold, io_valid} !== 2'b10) begin
          $display("FAIL timeout_wait cycle=%0d got hold=%b valid=%b exp 1 0", i, pc_hold, io_valid);
          failures++;
        end
      end else if ({io_valid, pc_hold, io_rdata, io_timeout} !== {1'b1, 1'b0, 16'h0000, 1'b1}) begin
        $display("FAIL timeout_done got valid=%b hold=%b rdata=%h to=%b exp 1 0 0000 1", io_valid, pc_hold, io_rdata, io_timeout);
        failures++;
      end
    end
    io_read = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_valid, io_timeout} !== 2'b01) begin
      $display("FAIL timeout_sticky got valid=%b to=%b exp 0 1", io_valid, io_timeout);
      failures++;
    end
    switches = 16'h5A5A; io_read = 1'b1; confirm_button = 1'b1;
    wait_valid(20, got, hold_ok);
    checks++;
    if ({got, hold_ok, io_rdata, io_timeout} !== {1'b1, 1'b1, 16'h5A5A, 1'b0}) begin
      $display("FAIL timeout_clear got valid=%b hold_ok=%b rdata=%h to=%b exp 1 1 5a5a 0", got, hold_ok, io_rdata, io_timeout);
      failures++;
    end
    io_read = 1'b0;
    @(negedge clock);
    confirm_button = 1'b0;
    repeat (12) @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid_wait;
    switches = 16'h9999; io_read = 1'b1; switch_ctrl = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    #1;
    checks++;
    if (pc_hold !== 1'b0) begin
      $display("FAIL midwait_reset_hold got=%b exp=0", pc_hold);
      failures++;
    end
    @(negedge clock);
    rst = 1'b0; io_read = 1'b0;
    @(negedge clock);
    checks++;
    if ({pc_hold, io_valid, io_rdata, io_timeout} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
      $display("FAIL midwait_after got hold=%b valid=%b rdata=%h to=%b exp 0 0 0000 0", pc_hold, io_valid, io_rdata, io_timeout);
      failures++;
    end
  endtask

  initial begin
    test_reset;
    test_basic_read;
    test_glitch;
    test_back_to_back;
    test_no_switch_ctrl;
`ifdef IO_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
